macguffin_key_schedule: RTL and testbench



---
 rtl/macguffin_key_schedule.sv | 150 +++++++++++++++
 tb/tb_macguffin_key_schedule.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/macguffin_key_schedule.sv
// macguffin_key_schedule: MacGuffin key expansion; a key_setup controller drives an iterative
// 32-round MacGuffin core over an AXI-Stream loop, and the core reads the live round-key table.
module mcg_encrypt (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:31][47:0] round_keys,
  input  logic [63:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready
);
  // Input bit numbers per S-box: two from a, two from b, two from c (LSB of the index first)
  localparam logic [0:7][0:5][3:0] sbits = {
    24'h2569BD, 24'h147A8E, 24'h368D0F, 24'hCE124A,
    24'h0A3E6C, 24'h78CF15, 24'h9F5B27, 24'hBD0439
  };
  // DES S1..S8, row-major; MacGuffin keeps output bits 3 and 0 of each entry
  localparam logic [0:7][0:63][3:0] des_sbox = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };
  logic [15:0] r0, r1, r2, r3, a, b, c, f;
  logic [47:0] rk;
  logic [4:0]  rnd;
  logic        busy;
  function automatic logic [15:0] swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction
  assign rk = round_keys[rnd];
  assign a = r1 ^ swap(rk[47:32]);
  assign b = r2 ^ swap(rk[31:16]);
  assign c = r3 ^ swap(rk[15:0]);
  for (genvar s = 0; s < 8; s++) begin : g_sbox
    logic [5:0] idx;
    assign idx = {c[sbits[s][5]], c[sbits[s][4]], b[sbits[s][3]],
                  b[sbits[s][2]], a[sbits[s][1]], a[sbits[s][0]]};
    assign f[2*s+:2] = {des_sbox[s][{idx[5], idx[0], idx[4:1]}][3],
                        des_sbox[s][{idx[5], idx[0], idx[4:1]}][0]};
  end
  assign s_axis_tready = !busy && !m_axis_tvalid;
  assign m_axis_tdata = {swap(r0), swap(r1), swap(r2), swap(r3)};
  always_ff @(posedge clk)
    if (rst) begin
      busy          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      rnd           <= '0;
      {r0, r1, r2, r3} <= '0;
    end else if (busy) begin
      {r0, r1, r2, r3} <= {r1, r2, r3, r0 ^ f};
      rnd           <= rnd + 5'd1;
      busy          <= rnd != 5'd31;
      m_axis_tvalid <= rnd == 5'd31;
    end else if (m_axis_tvalid) begin
      m_axis_tvalid <= !m_axis_tready;
    end else if (s_axis_tvalid) begin
      {r0, r1, r2, r3} <= {swap(s_axis_tdata[63:48]), swap(s_axis_tdata[47:32]),
                           swap(s_axis_tdata[31:16]), swap(s_axis_tdata[15:0])};
      busy <= 1'b1;
      rnd  <= '0;
    end
endmodule

module mcg_key_setup (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      key,
  output logic [0:31][47:0] round_keys,
  output logic              key_ready,
  output logic [63:0]       s_axis_tdata,
  output logic              s_axis_tvalid,
  input  logic              s_axis_tready,
  input  logic [63:0]       m_axis_tdata,
  input  logic              m_axis_tvalid,
  output logic              m_axis_tready
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  state_t      state;
  logic [63:0] k0, k1;
  logic [4:0]  i;
  logic        j;
  assign s_axis_tdata = j ? k1 : k0;
  always_ff @(posedge clk)
    if (rst) begin
      state         <= IDLE;
      k0            <= '0;
      k1            <= '0;
      i             <= '0;
      j             <= 1'b0;
      round_keys    <= '0;
      key_ready     <= 1'b0;
      s_axis_tvalid <= 1'b0;
      m_axis_tready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          k0            <= key[127:64];
          k1            <= key[63:0];
          s_axis_tvalid <= 1'b1;
          state         <= SEND;
        end
        SEND: if (s_axis_tready) begin
          s_axis_tvalid <= 1'b0;
          m_axis_tready <= 1'b1;
          state         <= WAIT;
        end
        // The table changes only here, after the core has finished and before the next send
        WAIT: if (m_axis_tvalid) begin
          k0            <= j ? k0 : m_axis_tdata;
          k1            <= j ? m_axis_tdata : k1;
          round_keys[i] <= round_keys[i] ^ m_axis_tdata[63:16];
          m_axis_tready <= 1'b0;
          j             <= ~j;
          i             <= j ? i + 5'd1 : i;
          key_ready     <= j && i == 5'd31;
          s_axis_tvalid <= !(j && i == 5'd31);
          state         <= (j && i == 5'd31) ? DONE : SEND;
        end
        default: ;
      endcase
    end
endmodule

module macguffin_key_schedule (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      key,
  output logic [0:31][47:0] round_keys,
  output logic              key_ready
);
  logic [63:0] s_axis_tdata, m_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready;
  mcg_key_setup u_key_setup (
    .clk(clk), .rst(rst), .key(key), .round_keys(round_keys), .key_ready(key_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );
  mcg_encrypt u_encryption (
    .clk(clk), .rst(rst), .round_keys(round_keys),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );
endmodule

// File: tb/tb_macguffin_key_schedule.sv
// tb_macguffin_key_schedule: directed key-schedule runs checked against a reference mcg_keyset model.
module tb_macguffin_key_schedule;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [127:0]      key = '0;
  logic [0:31][47:0] round_keys;
  logic              key_ready;
  int                checks = 0;
  int                errors = 0;
  logic [47:0]       mt [32];
  localparam logic [127:0] key_a = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] key_b = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  int sb_in [8][6] = '{'{2,5,6,9,11,13}, '{1,4,7,10,8,14}, '{3,6,8,13,0,15}, '{12,14,1,2,4,10},
                       '{0,10,3,14,6,12}, '{7,8,12,15,1,5}, '{9,15,5,11,2,7}, '{11,13,0,4,3,9}};
  logic [255:0] des_rows [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  macguffin_key_schedule dut (.clk(clk), .rst(rst), .key(key), .round_keys(round_keys), .key_ready(key_ready));

  always #5 clk = ~clk;

  function automatic logic [15:0] fmodel(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [15:0]  f, w;
    logic [255:0] t;
    logic [3:0]   v;
    int           idx, n;
    f = '0;
    for (int s = 0; s < 8; s++) begin
      idx = 0;
      for (int k = 0; k < 6; k++) begin
        w = (k < 2) ? a : (k < 4) ? b : c;
        idx = idx | (int'(w[sb_in[s][k]]) << k);
      end
      n = ((idx >> 5) * 2 + (idx & 1)) * 16 + ((idx >> 1) & 15);
      t = des_rows[s];
      v = t[255 - 4*n -: 4];
      f[2*s +: 2] = {v[3], v[0]};
    end
    return f;
  endfunction

  function automatic logic [63:0] model_enc(input logic [63:0] blk);
    logic [15:0] r [4];
    logic [15:0] t, k0, k1, k2;
    logic [47:0] k;
    for (int q = 0; q < 4; q++) r[q] = {blk[55 - 16*q -: 8], blk[63 - 16*q -: 8]};
    for (int rd = 0; rd < 32; rd++) begin
      k  = mt[rd];
      k0 = {k[39:32], k[47:40]};
      k1 = {k[23:16], k[31:24]};
      k2 = {k[7:0], k[15:8]};
      t = r[0] ^ fmodel(r[1] ^ k0, r[2] ^ k1, r[3] ^ k2);
      r[0] = r[1]; r[1] = r[2]; r[2] = r[3]; r[3] = t;
    end
    return {r[0][7:0], r[0][15:8], r[1][7:0], r[1][15:8], r[2][7:0], r[2][15:8], r[3][7:0], r[3][15:8]};
  endfunction

  task automatic model_keyset(input logic [127:0] k);
    logic [63:0] kk [2];
    logic [63:0] ct;
    for (int i = 0; i < 32; i++) mt[i] = '0;
    kk[0] = k[127:64];
    kk[1] = k[63:0];
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 2; j++) begin
        ct = model_enc(kk[j]);
        kk[j] = ct;
        mt[i] = mt[i] ^ ct[63:16];
      end
  endtask

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 32; i++) begin
      checks++;
      assert (round_keys[i] === mt[i]) else begin
        errors++;
        $error("FAIL %s rk[%0d]: got %h expected %h", tag, i, round_keys[i], mt[i]);
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    checks++;
    assert (round_keys === '0) else begin
      errors++;
      $error("FAIL %s table: got nonzero rk[0]=%h expected all zero", tag, round_keys[0]);
    end
    check({tag, " key_ready"}, 48'(key_ready), 48'd0);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (key_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (key_ready === 1'b1) else begin
      errors++;
      $error("FAIL %s key_ready: got %b expected 1 within %0d cycles", tag, key_ready, budget);
    end
  endtask

  initial begin
    key = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    wait_ready("zero_key", 2304);
    model_keyset('0);
    check_table("zero_key");

    model_keyset(key_a);
    rst = 1'b1;
    key = key_a;
    @(negedge clk);
    check_cleared("reset_from_done");
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("mid key_ready", 48'(key_ready), 48'd0);
    for (int i = 0; i < 4; i++) check($sformatf("mid rk[%0d] final", i), round_keys[i], mt[i]);
    for (int i = 6; i < 32; i++) check($sformatf("mid rk[%0d] zero", i), round_keys[i], 48'd0);
    key = ~key_a;
    wait_ready("key_a", 2304 - 300);
    check_table("key_a");
    for (int p = 0; p < 10; p++) begin
      repeat (100) @(negedge clk);
      check("hold key_ready", 48'(key_ready), 48'd1);
      check_table("hold");
    end

    rst = 1'b1;
    key = key_a;
    @(negedge clk);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    rst = 1'b1;
    key = key_b;
    @(negedge clk);
    check_cleared("mid_reset");
    rst = 1'b0;
    wait_ready("key_b", 2304);
    model_keyset(key_b);
    check_table("key_b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
